// File: rtl/ctrl_serial_pkg.sv
// ctrl_serial_pkg: shared modes, phases and state encodings for the serial control master
package ctrl_serial_pkg;
  localparam logic [1:0] CTRL_SHIFT = 2'b00;
  localparam logic [1:0] CTRL_READ = 2'b01;
  localparam logic [1:0] CTRL_WRITE = 2'b11;
  localparam int HOLD_CYC_DEF = 3;
  localparam int RDY_TIMEOUT_DEF = 5;
  typedef enum logic [2:0] {PH_SHIFT_WR, PH_COMMIT, PH_SHIFT_ADDR, PH_FETCH, PH_READBACK} phase_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} top_state_e;
  typedef enum logic [2:0] {G_IDLE, G_SETUP, G_LOW, G_WAIT, G_TAIL, G_GAP} strobe_state_e;
  function automatic logic [1:0] mode_of(phase_e p);
    return p == PH_COMMIT ? CTRL_WRITE : p == PH_FETCH ? CTRL_READ : CTRL_SHIFT;
  endfunction
endpackage

// File: rtl/ctrl_serial_master_strobe.sv
// ctrl_strobe_gen: runs one SETUP/LOW/WAIT/TAIL/GAP strobe on the serial control port
module ctrl_strobe_gen
  import ctrl_serial_pkg::*;
#(
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int RDY_TIMEOUT = RDY_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       si,
  input  logic       ctrl_rdy,
  output logic       load_n,
  output logic [1:0] ctrl_mode,
  output logic       ctrl_si,
  output logic       done,
  output logic       timeout,
  output logic       so_sample
);
  strobe_state_e st;
  logic [3:0] cnt;
  assign done = st == G_GAP;
  assign so_sample = st == G_SETUP;
  // mode/si are only loaded from IDLE or GAP, where LOAD_N is already high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= G_IDLE;
      load_n <= 1'b1;
      ctrl_mode <= CTRL_SHIFT;
      ctrl_si <= 1'b0;
      cnt <= '0;
      timeout <= 1'b0;
    end else begin
      case (st)
        G_IDLE, G_GAP: begin
          st <= start ? G_SETUP : G_IDLE;
          ctrl_mode <= start ? mode : CTRL_SHIFT;
          ctrl_si <= start & si;
          timeout <= 1'b0;
        end
        G_SETUP: begin
          st <= G_LOW;
          load_n <= 1'b0;
          cnt <= '0;
        end
        G_LOW: begin
          cnt <= cnt + 1'b1;
          if (cnt == 4'(HOLD_CYC - 1)) begin
            st <= G_WAIT;
            cnt <= '0;
          end
        end
        G_WAIT: begin
          if (ctrl_rdy) st <= G_TAIL;
          else if (cnt == 4'(RDY_TIMEOUT - 1)) begin
            st <= G_GAP;
            load_n <= 1'b1;
            timeout <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        G_TAIL: begin
          st <= G_GAP;
          load_n <= 1'b1;
        end
        default: st <= G_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/ctrl_serial_master.sv
// ctrl_serial_master: sequences single-byte write/read requests onto the bit-serial control port
module ctrl_serial_master
  import ctrl_serial_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8,
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int RDY_TIMEOUT = RDY_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [1:0]        ctrl_mode,
  output logic              load_n,
  output logic              ctrl_si,
  input  logic              ctrl_rdy,
  input  logic              ctrl_so
);
  localparam int WW = ADDR_W + DATA_W;
  localparam int BW = $clog2(WW);
  top_state_e st;
  phase_e phase, nxt_phase;
  logic [BW-1:0] bit_cnt, nxt_bit;
  logic [WW-1:0] word, w;
  logic [DATA_W-1:0] rd_sh;
  logic acc, last, start, st_si, done, tmo, so_sample;
  logic [1:0] st_mode;
  // next-strobe selection: on acceptance the request itself seeds strobe 0
  always_comb begin
    acc = req_valid & req_ready;
    w = acc ? (req_we ? {req_addr, req_wdata} : WW'(req_addr)) : word;
    last = phase == PH_COMMIT || (phase == PH_READBACK && bit_cnt == BW'(DATA_W - 1));
    nxt_phase = phase;
    nxt_bit = bit_cnt + 1'b1;
    if (acc) begin
      nxt_phase = req_we ? PH_SHIFT_WR : PH_SHIFT_ADDR;
      nxt_bit = '0;
    end else if (phase == PH_SHIFT_WR && bit_cnt == BW'(WW - 1)) begin
      nxt_phase = PH_COMMIT;
      nxt_bit = '0;
    end else if (phase == PH_SHIFT_ADDR && bit_cnt == BW'(ADDR_W - 1)) begin
      nxt_phase = PH_FETCH;
      nxt_bit = '0;
    end else if (phase == PH_FETCH) begin
      nxt_phase = PH_READBACK;
      nxt_bit = '0;
    end
    start = acc | (done & ~tmo & ~last);
    st_mode = mode_of(nxt_phase);
    st_si = (nxt_phase == PH_SHIFT_WR || nxt_phase == PH_SHIFT_ADDR) && w[nxt_bit];
  end
  ctrl_strobe_gen #(.HOLD_CYC(HOLD_CYC), .RDY_TIMEOUT(RDY_TIMEOUT)) u_strobe (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(st_mode), .si(st_si), .ctrl_rdy(ctrl_rdy),
    .load_n(load_n), .ctrl_mode(ctrl_mode), .ctrl_si(ctrl_si), .done(done), .timeout(tmo),
    .so_sample(so_sample)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= S_IDLE;
      req_ready <= 1'b1;
      busy <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
      phase <= PH_SHIFT_WR;
      bit_cnt <= '0;
      word <= '0;
      rd_sh <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      if (so_sample && phase == PH_READBACK) rd_sh[bit_cnt[$clog2(DATA_W)-1:0]] <= ctrl_so;
      if (acc) begin
        st <= S_RUN;
        req_ready <= 1'b0;
        busy <= 1'b1;
        word <= w;
        phase <= nxt_phase;
        bit_cnt <= nxt_bit;
      end else if (st == S_RESP) st <= S_IDLE;
      else if (done && (tmo || last)) begin
        st <= S_RESP;
        req_ready <= 1'b1;
        busy <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_err <= tmo;
        if (!tmo && phase == PH_READBACK) rsp_rdata <= rd_sh;
      end else if (done) begin
        phase <= nxt_phase;
        bit_cnt <= nxt_bit;
      end
    end
  end
endmodule

// File: tb/tb_ctrl_serial_master.sv
// tb_ctrl_serial_master: directed bench with a serial slave model for ctrl_serial_master
module tb_ctrl_serial_master;
  import ctrl_serial_pkg::*;
  logic clk = 0, rst_n = 1, req_valid = 0, req_we = 0;
  logic [8:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err, busy, load_n, ctrl_si, ctrl_rdy, ctrl_so;
  logic [7:0] rsp_rdata;
  logic [1:0] ctrl_mode;
  int errors = 0, checks = 0;
  int rdy_s = 1;
  int lc = 0, n_strb = 0, viol = 0;
  logic [2:0] rcnt = '0;
  logic [1:0] m_log[256];
  logic si_log[256];
  int w_log[256];
  logic [16:0] sh = '0;
  logic [7:0] rb = '0;
  logic [7:0] mem[512];

  always #5 clk = ~clk;

  ctrl_serial_master dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy), .ctrl_mode(ctrl_mode), .load_n(load_n), .ctrl_si(ctrl_si),
    .ctrl_rdy(ctrl_rdy), .ctrl_so(ctrl_so)
  );

  // slave: raises RDY on WAIT sample rdy_s (never when 0); acts on the first low cycle of each strobe
  assign ctrl_rdy = !load_n && rdy_s != 0 && lc >= 2 + rdy_s;
  assign ctrl_so = rb[rcnt];

  always @(posedge clk) begin
    if (!load_n) begin
      lc <= lc + 1;
      if (lc == 0) begin
        m_log[n_strb] <= ctrl_mode;
        si_log[n_strb] <= ctrl_si;
        if (ctrl_mode == CTRL_WRITE) mem[sh[16:8]] <= sh[7:0];
        else if (ctrl_mode == CTRL_READ) begin
          rb <= mem[sh[16:8]];
          rcnt <= '0;
        end else begin
          sh <= {ctrl_si, sh[16:1]};
          rcnt <= rcnt + 1'b1;
        end
      end else if (ctrl_mode !== m_log[n_strb] || ctrl_si !== si_log[n_strb]) viol <= viol + 1;
    end else if (lc != 0) begin
      w_log[n_strb] <= lc;
      n_strb <= n_strb + 1;
      lc <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] got_bits(input int b, input int n);
    logic [16:0] r = '0;
    for (int i = 0; i < n; i++) r[i] = si_log[b + i];
    return r;
  endfunction

  function automatic int count_bad(input int b, input int n, input int e);
    int c = 0;
    for (int i = 0; i < n; i++) if (w_log[b + i] != e) c++;
    return c;
  endfunction

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("rsp_seen", 32'(rsp_valid), 1);
  endtask

  task automatic txn(input logic we, input logic [8:0] a, input logic [7:0] d, output int cyc);
    @(negedge clk);
    chk("ready_before", 32'(req_ready), 1);
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 0;
    chk("busy_after_acc", 32'({busy, req_ready}), 'b10);
    wait_rsp(cyc);
  endtask

  initial begin
    int cyc, base, k, seen;
    #1 rst_n = 0;
    #1;
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp", 32'({rsp_valid, rsp_err}), 0);
    chk("rst_rdata", 32'(rsp_rdata), 0);
    chk("rst_port", 32'({ctrl_mode, load_n, ctrl_si}), 'b0010);
    repeat (2) @(negedge clk);
    rst_n = 1;

    base = n_strb;
    txn(1, 9'h020, 8'h34, cyc);
    chk("wr_lat", 32'(cyc), 126);
    chk("wr_err", 32'(rsp_err), 0);
    chk("wr_bits", 32'(got_bits(base, 17)), 'h02034);
    chk("wr_commit_mode", 32'(m_log[base + 17]), 'b11);
    chk("wr_strobes", 32'(n_strb - base), 18);
    chk("wr_width5", 32'(count_bad(base, 18, 5)), 0);
    chk("wr_mem", 32'(mem[9'h020]), 'h34);
    chk("wr_rdata_kept", 32'(rsp_rdata), 0);

    base = n_strb;
    txn(0, 9'h020, 8'h00, cyc);
    chk("rd_lat", 32'(cyc), 126);
    chk("rd_data", 32'(rsp_rdata), 'h34);
    chk("rd_err", 32'(rsp_err), 0);
    chk("rd_addr_bits", 32'(got_bits(base, 9)), 'h020);
    chk("rd_fetch_mode", 32'(m_log[base + 9]), 'b01);
    chk("rd_rb_si", 32'(got_bits(base + 10, 8)), 0);
    chk("rd_strobes", 32'(n_strb - base), 18);

    rdy_s = 4;
    base = n_strb;
    txn(1, 9'h1A5, 8'hC3, cyc);
    chk("slow_wr_lat", 32'(cyc), 180);
    chk("slow_wr_width8", 32'(count_bad(base, 18, 8)), 0);
    base = n_strb;
    txn(0, 9'h1A5, 8'h00, cyc);
    chk("slow_rd_lat", 32'(cyc), 180);
    chk("slow_rd_data", 32'(rsp_rdata), 'hC3);
    chk("slow_rd_width8", 32'(count_bad(base, 18, 8)), 0);

    rdy_s = 0;
    base = n_strb;
    txn(1, 9'h011, 8'h5A, cyc);
    chk("to_lat", 32'(cyc), 10);
    chk("to_err", 32'(rsp_err), 1);
    chk("to_rdata_kept", 32'(rsp_rdata), 'hC3);
    chk("to_ready", 32'(req_ready), 1);
    chk("to_low_width", 32'(w_log[base]), 8);
    chk("to_strobes", 32'(n_strb - base), 1);
    @(negedge clk);
    chk("to_pulse", 32'(rsp_valid), 0);

    rdy_s = 1;
    base = n_strb;
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = 9'h1FF; req_wdata = 8'hFF;
    @(negedge clk);
    req_valid = 0;
    k = 0;
    while (!(n_strb - base == 5 && !load_n) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("reach_bit5", 32'(k < 300), 1);
    chk("bit5_si", 32'(ctrl_si), 1);
    rst_n = 0;
    #1;
    chk("mid_rst_port", 32'({ctrl_mode, load_n, ctrl_si}), 'b0010);
    chk("mid_rst_busy", 32'({busy, req_ready}), 'b01);
    repeat (2) @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("no_rsp_after_rst", 32'(seen), 0);

    base = n_strb;
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = 9'h055; req_wdata = 8'hA7;
    @(negedge clk);
    req_we = 0; req_wdata = 8'h00;
    chk("b2b_busy1", 32'({busy, req_ready}), 'b10);
    wait_rsp(cyc);
    chk("b2b_lat1", 32'(cyc), 126);
    chk("b2b_err1", 32'(rsp_err), 0);
    chk("b2b_ready_at_rsp", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 0;
    chk("b2b_second_acc", 32'({busy, req_ready, rsp_valid}), 'b100);
    wait_rsp(cyc);
    chk("b2b_lat2", 32'(cyc), 126);
    chk("b2b_rdata", 32'(rsp_rdata), 'hA7);
    chk("b2b_mem", 32'(mem[9'h055]), 'hA7);
    chk("b2b_strobes", 32'(n_strb - base), 36);

    chk("mode_si_stable_low", 32'(viol), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
